// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg: shared constants and helper functions for the AES S-box.
//   GF_POLY       reduction polynomial x^8+x^4+x^3+x+1 (low byte, 8'h1B)
//   AES_SBOX_C    forward affine constant (8'h63)
//   AES_INV_C     inverse affine constant (8'h05)
//   SBOX          FIPS-197 forward S-box table, indexed by input byte
//   INV_SBOX_FLAT inverse S-box packed 8 bits per entry (AES_SBOX_INV_EN only)
//   gf_mul        GF(2^8) multiply modulo GF_POLY
//   affine_fwd    forward affine transform including AES_SBOX_C
//   affine_inv    inverse affine transform including AES_INV_C
// Configuration macro: AES_SBOX_INV_EN (adds the inverse table).
// -----------------------------------------------------------------------------
package aes_pkg;

    localparam logic [7:0] GF_POLY    = 8'h1B;
    localparam logic [7:0] AES_SBOX_C = 8'h63;
    localparam logic [7:0] AES_INV_C  = 8'h05;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Shift-and-add multiply; the running multiplicand is reduced each step.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ GF_POLY) : {aa[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [7:0] affine_fwd(input logic [7:0] x);
        logic [7:0] b;
        for (int i = 0; i < 8; i++)
            b[i] = x[i] ^ x[(i + 4) % 8] ^ x[(i + 5) % 8] ^ x[(i + 6) % 8] ^ x[(i + 7) % 8];
        return b ^ AES_SBOX_C;
    endfunction

    // Inverse of affine_fwd: constant 8'h05 is A^-1 applied to 8'h63.
    function automatic logic [7:0] affine_inv(input logic [7:0] y);
        logic [7:0] b;
        for (int i = 0; i < 8; i++)
            b[i] = y[(i + 2) % 8] ^ y[(i + 5) % 8] ^ y[(i + 7) % 8];
        return b ^ AES_INV_C;
    endfunction

`ifdef AES_SBOX_INV_EN
    // Inverse table built at elaboration by scattering the forward table.
    function automatic logic [2047:0] gen_inv_table();
        logic [2047:0] t;
        t = '0;
        for (int i = 0; i < 256; i++)
            t[int'(SBOX[i]) * 8 +: 8] = 8'(i);
        return t;
    endfunction

    localparam logic [2047:0] INV_SBOX_FLAT = gen_inv_table();
`endif

endpackage

// File: rtl/aes_gf256_inv.sv
// -----------------------------------------------------------------------------
// aes_gf256_inv: combinational multiplicative inverse in GF(2^8) mod 0x11B.
// Itoh-Tsujii style: x^-1 = x^254 = x^2 * x^4 * ... * x^128, which also
// yields 0 for input 0 without a special case.
//   a    input  8  operand
//   y    output 8  a^-1 (0 for a == 0)
// -----------------------------------------------------------------------------
module aes_gf256_inv
    import aes_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] y
);

    logic [7:0] sq [8];   // sq[k] = a^(2^k)
    logic [7:0] acc;

    always_comb begin
        sq[0] = a;
        for (int k = 1; k < 8; k++)
            sq[k] = gf_mul(sq[k-1], sq[k-1]);
        acc = sq[1];
        for (int k = 2; k < 8; k++)
            acc = gf_mul(acc, sq[k]);
        y = acc;
    end

endmodule

// File: rtl/aes_sbox.sv
// -----------------------------------------------------------------------------
// aes_sbox: AES SubBytes S-box with combinational and registered outputs.
//   IMPL        "LUT" (constant table) or "LOGIC" (GF inverter + affine)
//   clk         rising edge loads byte_out_q
//   rst_n       asynchronous active-low clear of byte_out_q
//   byte_in     input byte
//   inv         (AES_SBOX_INV_EN only) 1 selects the inverse S-box
//   byte_out    S-box(byte_in), combinational
//   byte_out_q  byte_out registered on clk
// Configuration macro: AES_SBOX_INV_EN adds the inv port and inverse mapping.
// -----------------------------------------------------------------------------
module aes_sbox
    import aes_pkg::*;
#(
    parameter string IMPL = "LUT"
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] byte_in,
`ifdef AES_SBOX_INV_EN
    input  logic       inv,
`endif
    output logic [7:0] byte_out,
    output logic [7:0] byte_out_q
);

    generate
        if (IMPL == "LUT") begin : g_lut
            always_comb begin
`ifdef AES_SBOX_INV_EN
                byte_out = inv ? INV_SBOX_FLAT[{byte_in, 3'b000} +: 8] : SBOX[byte_in];
`else
                byte_out = SBOX[byte_in];
`endif
            end
        end else if (IMPL == "LOGIC") begin : g_logic
            logic [7:0] gf_in;
            logic [7:0] gf_out;

            aes_gf256_inv u_inv (
                .a (gf_in),
                .y (gf_out)
            );

            // Inverse direction: undo the affine first, then share the
            // inverter; the forward affine is bypassed on the way out.
            always_comb begin
`ifdef AES_SBOX_INV_EN
                gf_in    = inv ? affine_inv(byte_in) : byte_in;
                byte_out = inv ? gf_out : affine_fwd(gf_out);
`else
                gf_in    = byte_in;
                byte_out = affine_fwd(gf_out);
`endif
            end
        end else begin : g_bad
            $error("aes_sbox: IMPL must be LUT or LOGIC");
            assign byte_out = '0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) byte_out_q <= '0;
        else        byte_out_q <= byte_out;
    end

endmodule

// File: tb/tb_aes_sbox.sv
// -----------------------------------------------------------------------------
// tb_aes_sbox: checks the LUT and LOGIC builds of aes_sbox side by side
// against the FIPS-197 table, the registered path and the async reset.
// Configuration macro: AES_SBOX_INV_EN enables the inverse-map checks.
// -----------------------------------------------------------------------------
module tb_aes_sbox;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] byte_in = 8'h00;
`ifdef AES_SBOX_INV_EN
    logic       inv = 1'b0;
`endif
    logic [7:0] out_l, q_l, out_g, q_g;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    bit         mon_en    = 1'b0;
    bit         have_prev = 1'b0;
    logic [7:0] prev_exp  = 8'h00;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    aes_sbox #(.IMPL("LUT")) dut_lut (
        .clk        (clk),
        .rst_n      (rst_n),
        .byte_in    (byte_in),
`ifdef AES_SBOX_INV_EN
        .inv        (inv),
`endif
        .byte_out   (out_l),
        .byte_out_q (q_l)
    );

    aes_sbox #(.IMPL("LOGIC")) dut_logic (
        .clk        (clk),
        .rst_n      (rst_n),
        .byte_in    (byte_in),
`ifdef AES_SBOX_INV_EN
        .inv        (inv),
`endif
        .byte_out   (out_g),
        .byte_out_q (q_g)
    );

    // ---------------- reference table (FIPS-197) ----------------
    logic [7:0] fips [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // ---------------- compare helper ----------------
    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %02h want %02h (byte_in=%02h t=%0t)", name, act, req, byte_in, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    // Each negedge: the registered outputs must hold the value expected for
    // the byte presented one cycle earlier; then the combinational outputs
    // are checked against the head of the expected queue.
    always @(negedge clk) begin
        logic [7:0] e;
        if (mon_en) begin
            if (have_prev) begin
                check("reg_lut", q_l, prev_exp);
                check("reg_logic", q_g, prev_exp);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("comb_lut", out_l, e);
                check("comb_logic", out_g, e);
                prev_exp  = e;
                have_prev = 1'b1;
            end else begin
                have_prev = 1'b0;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic drive(input logic [7:0] x, input logic iv, input logic [7:0] e);
        @(posedge clk);
        #1;
        byte_in = x;
`ifdef AES_SBOX_INV_EN
        inv = iv;
`else
        if (iv) $display("note: inverse request ignored in forward-only build");
`endif
        exp_q.push_back(e);
    endtask

    task automatic drain();
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        exp_q.delete();
        mon_en    = 1'b0;
        have_prev = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    logic [7:0] dir_in  [7] = '{8'h53, 8'h00, 8'h52, 8'hFF, 8'h63, 8'h01, 8'hC9};
    logic [7:0] dir_exp [7] = '{8'hED, 8'h63, 8'h00, 8'h16, 8'hFB, 8'h7C, 8'hDD};

    initial begin
        // Reset state: register cleared, combinational path unaffected.
        #1;
        rst_n   = 1'b0;
        byte_in = 8'h53;
        #2;
        check("rst_q_lut", q_l, 8'h00);
        check("rst_q_logic", q_g, 8'h00);
        check("rst_comb_lut", out_l, 8'hED);
        check("rst_comb_logic", out_g, 8'hED);
        @(posedge clk);
        #1;
        check("rst_hold_lut", q_l, 8'h00);
        check("rst_hold_logic", q_g, 8'h00);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("first_load_lut", q_l, 8'hED);
        check("first_load_logic", q_g, 8'hED);

        // Directed boundary vectors then the full sweep.
        mon_en = 1'b1;
        for (int i = 0; i < 7; i++) drive(dir_in[i], 1'b0, dir_exp[i]);
        for (int i = 0; i < 256; i++) drive(8'(i), 1'b0, fips[i]);
        drain();

        // Async reset between edges while byte_out_q holds ED.
        @(posedge clk);
        #1;
        byte_in = 8'h53;
        @(posedge clk);
        #1;
        check("pre_arst_lut", q_l, 8'hED);
        check("pre_arst_logic", q_g, 8'hED);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_q_lut", q_l, 8'h00);
        check("arst_q_logic", q_g, 8'h00);
        check("arst_comb_lut", out_l, 8'hED);
        check("arst_comb_logic", out_g, 8'hED);
        #1;
        rst_n   = 1'b1;
        byte_in = 8'h00;
        @(posedge clk);
        #1;
        check("post_arst_lut", q_l, 8'h63);
        check("post_arst_logic", q_g, 8'h63);

`ifdef AES_SBOX_INV_EN
        // Inverse map: directed points then inv(S(x)) == x for every x.
        mon_en = 1'b1;
        drive(8'hED, 1'b1, 8'h53);
        drive(8'h63, 1'b1, 8'h00);
        drive(8'h16, 1'b1, 8'hFF);
        for (int i = 0; i < 256; i++) drive(fips[i], 1'b1, 8'(i));
        drive(8'h53, 1'b0, 8'hED);
        drain();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
